// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add MULT/MULTU, restoring DIV/DIVU,
// MTHI/MTLO writes, and an EX-stage stall request while an operation is in flight.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  Op,
  input  logic [31:0] Operand_A,
  input  logic [31:0] Operand_B,
  input  logic        EX_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        EX_ALU_Stall
);

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_MULT   = 3'd1;
  localparam logic [2:0] OP_MULTU  = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_DIVU   = 3'd4;
  localparam logic [2:0] OP_MTHI   = 3'd5;
  localparam logic [2:0] OP_MTLO   = 3'd6;
  localparam logic [2:0] OP_MFHILO = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_SIGNFIX} state_t;

  // Context latched at issue; neg_lo/neg_hi are the result negations applied in SIGNFIX.
  typedef struct packed {
    logic is_div;
    logic signed_op;
    logic neg_lo;
    logic neg_hi;
  } ctx_t;

  state_t      state, state_nx;
  logic [4:0]  count, count_nx;
  logic [63:0] acc, acc_nx;
  logic [31:0] opnd, opnd_nx;
  ctx_t        ctx, ctx_nx;
  logic [31:0] hi_nx, lo_nx;

  logic        issue;
  logic        is_div_op, is_signed_op;
  logic        a_neg, b_neg, sign_diff;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic        div_fits;
  logic [31:0] div_rem;
  logic [63:0] div_step;
  logic [63:0] acc_neg;

  assign issue        = (state == S_IDLE) && !EX_Stall && (Op != OP_NONE) && (Op != OP_MFHILO);
  assign is_div_op    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign is_signed_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign a_neg        = is_signed_op & Operand_A[31];
  assign b_neg        = is_signed_op & Operand_B[31];
  assign sign_diff    = a_neg ^ b_neg;
  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  assign a_mag        = a_neg ? (32'd0 - Operand_A) : Operand_A;
  assign b_mag        = b_neg ? (32'd0 - Operand_B) : Operand_B;

  // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB then shift right.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_step = {mul_sum, acc[31:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left and trial-subtract the divisor.
  assign div_fits = acc[63:31] >= {1'b0, opnd};
  assign div_rem  = acc[62:31] - opnd;
  assign div_step = div_fits ? {div_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  assign acc_neg  = 64'd0 - acc;

  assign EX_ALU_Stall = (state != S_IDLE) && (Op != OP_NONE);

  always_comb begin
    state_nx = state;
    count_nx = count;
    acc_nx   = acc;
    opnd_nx  = opnd;
    ctx_nx   = ctx;
    hi_nx    = HI;
    lo_nx    = LO;
    case (state)
      S_IDLE: begin
        if (issue) begin
          case (Op)
            OP_MTHI: hi_nx = Operand_A;
            OP_MTLO: lo_nx = Operand_A;
            default: begin
              ctx_nx.is_div    = is_div_op;
              ctx_nx.signed_op = is_signed_op;
              if (is_div_op) begin
                if (Operand_B == 32'd0) begin
                  // Zero divisor: the raw dividend falls through as remainder, quotient all ones.
                  acc_nx        = {32'd0, Operand_A};
                  opnd_nx       = 32'd0;
                  ctx_nx.neg_lo = 1'b0;
                  ctx_nx.neg_hi = 1'b0;
                end else begin
                  acc_nx        = {32'd0, a_mag};
                  opnd_nx       = b_mag;
                  ctx_nx.neg_lo = sign_diff;
                  ctx_nx.neg_hi = a_neg;
                end
              end else begin
                acc_nx        = {32'd0, b_mag};
                opnd_nx       = a_mag;
                ctx_nx.neg_lo = sign_diff;
                ctx_nx.neg_hi = sign_diff;
              end
              count_nx = 5'd31;
              state_nx = is_div_op ? S_DIV : S_MUL;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_nx   = mul_step;
        count_nx = count - 5'd1;
        if (count == 5'd0) begin
          count_nx = 5'd0;
          if (ctx.signed_op) begin
            state_nx = S_SIGNFIX;
          end else begin
            {hi_nx, lo_nx} = mul_step;
            state_nx       = S_IDLE;
          end
        end
      end
      S_DIV: begin
        acc_nx   = div_step;
        count_nx = count - 5'd1;
        if (count == 5'd0) begin
          count_nx = 5'd0;
          if (ctx.signed_op) begin
            state_nx = S_SIGNFIX;
          end else begin
            {hi_nx, lo_nx} = div_step;
            state_nx       = S_IDLE;
          end
        end
      end
      S_SIGNFIX: begin
        if (ctx.is_div) begin
          hi_nx = ctx.neg_hi ? acc_neg_hi(acc[63:32]) : acc[63:32];
          lo_nx = ctx.neg_lo ? (32'd0 - acc[31:0]) : acc[31:0];
        end else begin
          {hi_nx, lo_nx} = ctx.neg_lo ? acc_neg : acc;
        end
        state_nx = S_IDLE;
      end
    endcase
  end

  function automatic logic [31:0] acc_neg_hi(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 5'd0;
      acc   <= 64'd0;
      opnd  <= 32'd0;
      ctx   <= '0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      acc   <= acc_nx;
      opnd  <= opnd_nx;
      ctx   <= ctx_nx;
      HI    <= hi_nx;
      LO    <= lo_nx;
    end
  end

endmodule
